// File: rtl/counter8_seq_ctrl.sv
// counter8_seq_ctrl: command sequencer that preloads an external up-counter and issues a
// fixed number of enabled increments, flagging roll-over and completion.
module counter8_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [WIDTH-1:0] cmd_start_i,
   input  logic [LEN_W-1:0] cmd_len_i,
   input  logic             pause_i,
   input  logic             abort_i,
   output logic             ctr_load_o,
   output logic             ctr_en_o,
   output logic [WIDTH-1:0] ctr_data_o,
   input  logic [WIDTH-1:0] ctr_cnt_i,
   output logic             busy_o,
   output logic [LEN_W-1:0] remain_o,
   output logic             done_o,
   output logic             wrap_o
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
   state_e state_q, state_d;
   logic [LEN_W-1:0] remain_q, remain_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic wrap_q, wrap_d;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         remain_q <= '0;
         data_q   <= '0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         data_q   <= data_d;
         wrap_q   <= wrap_d;
      end
   end
   // abort gates every strobe in the same cycle it is seen
   always_comb begin
      busy_o      = state_q != IDLE;
      cmd_ready_o = state_q == IDLE && !abort_i;
      ctr_load_o  = state_q == LOAD && !abort_i;
      ctr_en_o    = state_q == RUN && !pause_i && !abort_i;
      done_o      = state_q == DONE && !abort_i;
      ctr_data_o  = data_q;
      remain_o    = remain_q;
      wrap_o      = wrap_q;
      state_d     = state_q;
      remain_d    = remain_q;
      data_d      = data_q;
      wrap_d      = ctr_en_o && ctr_cnt_i == {WIDTH{1'b1}};
      case (state_q)
         IDLE: if (cmd_valid_i && cmd_ready_o) begin
            state_d  = LOAD;
            remain_d = cmd_len_i;
            data_d   = cmd_start_i;
         end
         LOAD: state_d = remain_q == '0 ? DONE : RUN;
         RUN: if (ctr_en_o && remain_q != '0) begin
            remain_d = remain_q - 1'b1;
            state_d  = remain_q == LEN_W'(1) ? DONE : RUN;
         end
         default: state_d = IDLE;
      endcase
      if (abort_i && state_q != IDLE) begin
         state_d  = IDLE;
         remain_d = '0;
      end
   end
endmodule
